// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: drives PC, instruction memory and IR strobes
// and hands non-control opcodes to the execute datapath. Optional FETCH_SEQUENCER_SINGLE_STEP_EN adds step_i.
module fetch_sequencer #(
    parameter logic [3:0]  JMP_OP       = 4'hC,
    parameter logic [3:0]  JZ_OP        = 4'hD,
    parameter logic [3:0]  HLT_OP       = 4'hF,
    parameter logic [3:0]  NOP_OP       = 4'h0,
    parameter int unsigned EXEC_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    input  logic       step_i,
`endif
    input  logic [7:0] instr_i,
    input  logic       zero_i,
    input  logic       exec_done_i,
    output logic       mod_o,
    output logic       pcen_o,
    output logic       imen_o,
    output logic       iren_o,
    output logic [3:0] addr_o,
    output logic       exec_start_o,
    output logic [3:0] opcode_o,
    output logic       halted_o,
    output logic       error_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_JUMP,
        S_HALT
    } state_e;

    state_e           state_q, state_d;
    state_e           boundary_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    logic [3:0]       op;

    assign op      = instr_i[7:4];
    assign error_o = error_q;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    // armed: step_i seen low in IDLE; step_mode: current instruction is a single step
    logic step_armed_q, step_armed_d;
    logic step_mode_q, step_mode_d;
`endif

    // State, timeout counter and sticky error register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
            step_armed_q <= 1'b0;
            step_mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
            step_armed_q <= step_armed_d;
            step_mode_q  <= step_mode_d;
`endif
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        error_d      = error_q;
        mod_o        = 1'b0;
        pcen_o       = 1'b0;
        imen_o       = 1'b0;
        iren_o       = 1'b0;
        addr_o       = '0;
        exec_start_o = 1'b0;
        opcode_o     = '0;
        halted_o     = 1'b0;
        boundary_state = run_i ? S_FETCH : S_IDLE;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        step_armed_d = step_armed_q;
        step_mode_d  = step_mode_q;
        if (step_mode_q) begin
            boundary_state = S_IDLE;
        end
`endif

        case (state_q)
            S_IDLE: begin
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
                step_mode_d = 1'b0;
                if (run_i) begin
                    state_d = S_FETCH;
                end else if (step_i && step_armed_q) begin
                    state_d      = S_FETCH;
                    step_mode_d  = 1'b1;
                    step_armed_d = 1'b0;
                end else if (!step_i) begin
                    step_armed_d = 1'b1;
                end
`else
                if (run_i) begin
                    state_d = S_FETCH;
                end
`endif
            end
            S_FETCH: begin
                imen_o  = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                imen_o  = 1'b1;
                iren_o  = 1'b1;
                pcen_o  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_o = op;
                if (op == HLT_OP) begin
                    state_d = S_HALT;
                end else if (op == JMP_OP || (op == JZ_OP && zero_i)) begin
                    state_d = S_JUMP;
                end else if (op == JZ_OP || op == NOP_OP) begin
                    state_d = boundary_state;
                end else begin
                    exec_start_o = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // opcode stays visible while the datapath works on it
                opcode_o = op;
                if (exec_done_i) begin
                    state_d = boundary_state;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_JUMP: begin
                mod_o   = 1'b1;
                pcen_o  = 1'b1;
                addr_o  = instr_i[3:0];
                state_d = boundary_state;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; expected strobe patterns are
// hand-derived per state. Covers the single-step path when FETCH_SEQUENCER_SINGLE_STEP_EN is set.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_i, run_i, zero_i, exec_done_i;
    logic [7:0] instr_i;
    logic       mod_o, pcen_o, imen_o, iren_o, exec_start_o, halted_o, error_o;
    logic [3:0] addr_o, opcode_o;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    logic       step_i;
`endif

    int checks = 0;
    int errors = 0;

    // {mod, pcen, imen, iren, exec_start, halted, error}
    localparam logic [6:0] P_IDLE   = 7'b0000000;
    localparam logic [6:0] P_FETCH  = 7'b0010000;
    localparam logic [6:0] P_LOAD   = 7'b0111000;
    localparam logic [6:0] P_DEC    = 7'b0000000;
    localparam logic [6:0] P_DEC_X  = 7'b0000100;
    localparam logic [6:0] P_EXEC   = 7'b0000000;
    localparam logic [6:0] P_JUMP   = 7'b1100000;
    localparam logic [6:0] P_HALT   = 7'b0000010;
    localparam logic [6:0] P_HALT_E = 7'b0000011;

    logic [14:0] obs;
    assign obs = {mod_o, pcen_o, imen_o, iren_o, exec_start_o, halted_o, error_o, addr_o, opcode_o};

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .run_i        (run_i),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        .step_i       (step_i),
`endif
        .instr_i      (instr_i),
        .zero_i       (zero_i),
        .exec_done_i  (exec_done_i),
        .mod_o        (mod_o),
        .pcen_o       (pcen_o),
        .imen_o       (imen_o),
        .iren_o       (iren_o),
        .addr_o       (addr_o),
        .exec_start_o (exec_start_o),
        .opcode_o     (opcode_o),
        .halted_o     (halted_o),
        .error_o      (error_o)
    );

    // Advance one cycle; inputs change and outputs are sampled 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [6:0] pat, input logic [3:0] addr,
                       input logic [3:0] opc);
        logic [14:0] exp;
        exp = {pat, addr, opc};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; run_i = 1'b0; zero_i = 1'b0; exec_done_i = 1'b0; instr_i = 8'h00;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        step_i = 1'b0;
`endif
        tick();
        chk("reset", P_IDLE, 4'h0, 4'h0);
        rst_i = 1'b0;
        tick();
        chk("idle_hold", P_IDLE, 4'h0, 4'h0);

        // NOP stream: 3-cycle period
        run_i = 1'b1;
        tick(); chk("nop_fetch", P_FETCH, 4'h0, 4'h0);
        tick(); chk("nop_load", P_LOAD, 4'h0, 4'h0);
        tick(); chk("nop_decode", P_DEC, 4'h0, 4'h0);
        tick(); chk("nop_fetch2", P_FETCH, 4'h0, 4'h0);

        // Unconditional jump
        instr_i = 8'hC9;
        tick(); chk("jmp_load", P_LOAD, 4'h0, 4'h0);
        tick(); chk("jmp_decode", P_DEC, 4'h0, 4'hC);
        tick(); chk("jmp_jump", P_JUMP, 4'h9, 4'h0);
        tick(); chk("jmp_fetch", P_FETCH, 4'h0, 4'h0);

        // JZ not taken
        instr_i = 8'hD9; zero_i = 1'b0;
        tick(); tick(); chk("jz0_decode", P_DEC, 4'h0, 4'hD);
        tick(); chk("jz0_fetch", P_FETCH, 4'h0, 4'h0);

        // JZ taken
        zero_i = 1'b1;
        tick(); tick(); chk("jz1_decode", P_DEC, 4'h0, 4'hD);
        tick(); chk("jz1_jump", P_JUMP, 4'h9, 4'h0);
        zero_i = 1'b0;
        tick(); chk("jz1_fetch", P_FETCH, 4'h0, 4'h0);

        // Executed op, done in third EXEC cycle
        instr_i = 8'h35;
        tick(); tick(); chk("exe_decode", P_DEC_X, 4'h0, 4'h3);
        tick(); chk("exe_exec1", P_EXEC, 4'h0, 4'h3);
        tick();
        tick(); exec_done_i = 1'b1; chk("exe_exec3", P_EXEC, 4'h0, 4'h3);
        tick(); exec_done_i = 1'b0; chk("exe_fetch", P_FETCH, 4'h0, 4'h0);

        // Done arriving on the last allowed EXEC cycle wins over timeout
        tick(); tick(); chk("edge_decode", P_DEC_X, 4'h0, 4'h3);
        for (int i = 1; i <= 15; i++) tick();
        exec_done_i = 1'b1;
        chk("edge_exec15", P_EXEC, 4'h0, 4'h3);
        tick(); exec_done_i = 1'b0;
        chk("edge_fetch", P_FETCH, 4'h0, 4'h0);

        // Timeout: 15 EXEC cycles without done -> HALT with error
        tick(); tick();
        for (int i = 1; i <= 15; i++) tick();
        chk("to_exec15", P_EXEC, 4'h0, 4'h3);
        tick(); chk("to_halt", P_HALT_E, 4'h0, 4'h0);
        tick(); tick(); chk("to_stay", P_HALT_E, 4'h0, 4'h0);
        rst_i = 1'b1;
        tick(); chk("to_reset", P_IDLE, 4'h0, 4'h0);
        rst_i = 1'b0;

        // run_i dropped mid-EXEC completes the instruction then idles
        tick(); chk("drop_fetch", P_FETCH, 4'h0, 4'h0);
        tick(); tick(); tick();
        run_i = 1'b0;
        chk("drop_exec1", P_EXEC, 4'h0, 4'h3);
        tick(); exec_done_i = 1'b1;
        tick(); exec_done_i = 1'b0;
        chk("drop_idle", P_IDLE, 4'h0, 4'h0);
        tick(); chk("drop_idle2", P_IDLE, 4'h0, 4'h0);

        // Reset mid-EXEC abandons the instruction
        run_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rst_exec1", P_EXEC, 4'h0, 4'h3);
        rst_i = 1'b1;
        tick(); chk("rst_idle", P_IDLE, 4'h0, 4'h0);
        rst_i = 1'b0;
        tick(); chk("rst_refetch", P_FETCH, 4'h0, 4'h0);

        // HLT
        instr_i = 8'hF0;
        tick(); tick(); chk("hlt_decode", P_DEC, 4'h0, 4'hF);
        tick(); chk("hlt_halt", P_HALT, 4'h0, 4'h0);
        tick(); chk("hlt_stay", P_HALT, 4'h0, 4'h0);
        rst_i = 1'b1; run_i = 1'b0; instr_i = 8'h00;
        tick(); rst_i = 1'b0;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        // Single step: one instruction, then IDLE until step_i is re-armed
        tick();
        step_i = 1'b1;
        tick(); chk("ss_fetch", P_FETCH, 4'h0, 4'h0);
        tick(); tick(); chk("ss_decode", P_DEC, 4'h0, 4'h0);
        tick(); chk("ss_idle", P_IDLE, 4'h0, 4'h0);
        tick(); chk("ss_no_rearm", P_IDLE, 4'h0, 4'h0);
        step_i = 1'b0;
        tick(); step_i = 1'b1;
        tick(); chk("ss_refetch", P_FETCH, 4'h0, 4'h0);
        step_i = 1'b0;
        tick(); tick(); tick();
        chk("ss_idle2", P_IDLE, 4'h0, 4'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- FSM that drives the control strobes of the instruction read unit: PC enable, instruction-memory read, IR load, PC-source mux select and jump address.
- Sequences fetch -> decode -> execute/jump per instruction.
- Hands non-control opcodes to the execute datapath via a start/done handshake, with a bounded wait.
- Sits between the instruction read unit (consumes its 8-bit instruction output) and the ALU/register-file control.

Parameters:
- JMP_OP, 4'hC, opcode (instr[7:4]) for unconditional jump to instr[3:0]
- JZ_OP, 4'hD, opcode for jump to instr[3:0] when zero_i=1
- HLT_OP, 4'hF, opcode that stops the sequencer until reset
- NOP_OP, 4'h0, opcode with no execute phase
- EXEC_TIMEOUT, 15, max cycles spent in EXEC waiting for exec_done_i (1..255)

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- run_i  input  1  level; 1 = continuous execution, 0 = stop at next instruction boundary
- instr_i  input  8  instruction word from IR (valid from DECODE onward)
- zero_i  input  1  zero flag from datapath, sampled in DECODE
- exec_done_i  input  1  execute datapath finished current instruction
- mod_o  output  1  PC source select: 0 = incrementer, 1 = addr_o
- pcen_o  output  1  PC load enable
- imen_o  output  1  instruction memory read enable
- iren_o  output  1  IR load enable
- addr_o  output  4  jump target to PC mux
- exec_start_o  output  1  one-cycle request to execute datapath
- opcode_o  output  4  instr_i[7:4] passed to execute datapath
- halted_o  output  1  sequencer in HALT
- error_o  output  1  sticky execute-timeout flag

Behaviour:
- States: IDLE, FETCH, LOAD, DECODE, EXEC, JUMP, HALT. Encoding is free.
- Strobes decode from state only (Moore), except exec_start_o (DECODE plus opcode).
- Reset (rst_i=1 at clock edge):
  - state=IDLE, timeout counter=0, error_o=0.
  - All strobes 0, addr_o=0, halted_o=0.
  - rst_i has priority over every transition, including mid-EXEC; the in-flight instruction is abandoned and exec_start_o is not reissued.
- IDLE: strobes 0; run_i=1 -> FETCH.
- FETCH: imen_o=1; -> LOAD.
- LOAD: imen_o=1, iren_o=1, pcen_o=1, mod_o=0.
  - IR captures memory data and PC increments at the same edge.
  - PC wrap 4'hF -> 4'h0 is native 4-bit overflow; no special handling.
  - -> DECODE.
- DECODE: opcode_o=instr_i[7:4]; decode priority:
  - HLT_OP -> HALT.
  - JMP_OP, or JZ_OP with zero_i=1 -> JUMP.
  - JZ_OP with zero_i=0, or NOP_OP -> boundary.
  - Any other opcode -> exec_start_o=1 for this cycle only; -> EXEC; counter cleared.
- EXEC:
  - exec_done_i=1 -> boundary.
  - Else counter+1. When counter==EXEC_TIMEOUT-1 and exec_done_i=0 -> error_o=1, -> HALT.
  - exec_done_i in the same cycle as the timeout: done wins.
  - exec_done_i outside EXEC is ignored.
- JUMP: mod_o=1, pcen_o=1, addr_o=instr_i[3:0]; -> boundary.
- Boundary: run_i=1 -> FETCH, else -> IDLE. run_i is sampled only here and in IDLE; deasserting mid-instruction completes the instruction.
- HALT: halted_o=1, strobes 0, exits only via rst_i.
- addr_o=0 in all states except JUMP.
- Throughput: 3 cycles per NOP or not-taken JZ, 4 per jump, 4+N per executed instruction (N = cycles to exec_done_i, counted from the EXEC entry cycle).

Optional Feature:
- Macro: FETCH_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds port step_i (input, 1).
  - In IDLE with run_i=0, step_i=1 -> FETCH and executes exactly one instruction, then returns to IDLE regardless of run_i.
  - A new step requires step_i to be seen low for at least one cycle in IDLE; an edge-armed flag, cleared by reset.
  - HALT behaviour is unchanged.
- Undefined: no step_i port; only run_i starts execution.

Test Plan:
- Reset then run_i=1, instr_i=8'h00 constant -> cycles: FETCH imen_o=1; LOAD imen_o=iren_o=pcen_o=1, mod_o=0; DECODE; FETCH again. Period 3 cycles, exec_start_o never asserted.
- instr_i=8'hC9 -> in JUMP cycle mod_o=1, pcen_o=1, addr_o=4'h9; next cycle FETCH. instr_i=8'hD9 with zero_i=0 -> no JUMP, returns to FETCH after DECODE.
- instr_i=8'h35, exec_done_i after 3 EXEC cycles -> exec_start_o high exactly one cycle in DECODE, opcode_o=4'h3. FETCH follows the done cycle. error_o=0.
- instr_i=8'h35, exec_done_i held 0 -> after EXEC_TIMEOUT=15 cycles: error_o=1, halted_o=1, stays halted with run_i=1. rst_i pulse clears both.
- run_i dropped during EXEC -> instruction completes, state IDLE, no further imen_o. rst_i asserted mid-EXEC -> next cycle IDLE, all outputs 0.
- instr_i=8'hF0 -> HALT after DECODE, halted_o=1, all strobes 0. With SINGLE_STEP_EN: step_i held high -> exactly one 3-cycle fetch/decode then IDLE.
